// File: rtl/spi_byte_receiver.sv
// Mode-0, MSB-first SPI peripheral receiver: synchronizes the pins, assembles
// bytes under CS, and queues them in a small FIFO with a valid/ready output.
module spi_byte_receiver #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spiclk,
  input  logic       spics,
  input  logic       spimosi,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_active,
  output logic       abort,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Pin synchronizers plus one history stage on SCK and CS for edge detection
  logic sck_m, sck_s, sck_d;
  logic cs_m, cs_s, cs_d;
  logic mosi_m, mosi_s;
  logic vld_m, vld_s;

  // NOTE: every register below uses non-blocking assignment so that all flops
  // sample the values from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_m  <= 1'b0;
      sck_s  <= 1'b0;
      sck_d  <= 1'b0;
      cs_m   <= 1'b1;
      cs_s   <= 1'b1;
      cs_d   <= 1'b1;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
      vld_m  <= 1'b0;
      vld_s  <= 1'b0;
    end else begin
      sck_m  <= spiclk;
      sck_s  <= sck_m;
      sck_d  <= sck_s;
      cs_m   <= spics;
      cs_s   <= cs_m;
      cs_d   <= cs_s;
      mosi_m <= spimosi;
      mosi_s <= mosi_m;
      vld_m  <= 1'b1;
      vld_s  <= vld_m;
    end
  end

  logic sck_rise, cs_fall, cs_rise;

  assign sck_rise = sck_s & ~sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  // The CS reset value would fake a falling edge when CS is already low at
  // reset exit; arming only after a pin-derived CS high blocks that frame.
  state_t     state;
  logic       armed;
  logic [2:0] bitcnt;
  logic [6:0] shreg;
  logic       push;
  logic [7:0] push_data;

  assign push      = (state == SHIFT) & sck_rise & ~cs_rise & (bitcnt == 3'd7);
  assign push_data = {shreg, mosi_s};

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      armed        <= 1'b0;
      bitcnt       <= 3'd0;
      shreg        <= 7'd0;
      frame_active <= 1'b0;
      abort        <= 1'b0;
    end else begin
      abort <= 1'b0;
      if (vld_s && cs_s) begin
        armed <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cs_fall && armed) begin
            state        <= SHIFT;
            bitcnt       <= 3'd0;
            shreg        <= 7'd0;
            frame_active <= 1'b1;
          end
        end
        SHIFT: begin
          // CS release outranks a coincident SCK edge: no sample, no push
          if (cs_rise) begin
            state        <= IDLE;
            frame_active <= 1'b0;
            abort        <= (bitcnt != 3'd0);
          end else if (sck_rise) begin
            shreg  <= {shreg[5:0], mosi_s};
            bitcnt <= bitcnt + 3'd1;
          end
        end
        default: begin
          state        <= IDLE;
          frame_active <= 1'b0;
        end
      endcase
    end
  end

  // Byte FIFO; pointers carry an extra wrap bit to tell full from empty
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = rx_valid & rx_ready;
  assign wr_en = push & (~full | pop);

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are live, and rx_data is forced to zero while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign rx_valid = ~empty;
  assign rx_data  = rx_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

endmodule
